hazard_stall_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage pipelined CPU, beside the operand-forwarding logic.
- Decides stall, bubble and flush for the IF/ID, ID/EX and EX/MEM registers.
- Covers cases forwarding cannot resolve: load-use, taken-branch redirect, and multi-cycle MDU ops held in EX until done.
- Keeps a watchdog on MDU operations and saturating performance counters.

---
 rtl/hazard_stall_ctrl_if.sv | 15 +
 rtl/hazard_stall_ctrl.sv | 56 +++++
 tb/tb_hazard_stall_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: pipeline-to-hazard-controller signal bundle
interface hazard_stall_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0] ID_rs1, ID_rs2, EX_rd;
  logic ID_use_rs1, ID_use_rs2, EX_MemRead, EX_branch_taken, EX_mdu_start, mdu_done;
  logic PC_write, IFID_write, IFID_flush, IDEX_write, IDEX_flush, EXMEM_flush, mdu_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  modport master (
    output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_MemRead, EX_rd, EX_branch_taken, EX_mdu_start, mdu_done,
    input PC_write, IFID_write, IFID_flush, IDEX_write, IDEX_flush, EXMEM_flush, mdu_timeout, stall_cycles, flush_count
  );
  modport slave (
    input ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_MemRead, EX_rd, EX_branch_taken, EX_mdu_start, mdu_done,
    output PC_write, IFID_write, IFID_flush, IDEX_write, IDEX_flush, EXMEM_flush, mdu_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: stall/bubble/flush control for load-use, branch redirect and MDU waits
module hazard_stall_ctrl #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  hazard_stall_ctrl_if.slave bus
);
  localparam int WW = $clog2(MDU_TIMEOUT) + 1;
  typedef enum logic {RUN, MDU_WAIT} state_t;
  state_t state;
  logic [WW-1:0] wait_cnt;
  logic load_use, branch, mdu_go, lu, wd, hold, pc_wr;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic timeout_q;
  always_comb begin
    load_use = bus.EX_MemRead && bus.EX_rd != 5'd0 &&
               ((bus.ID_use_rs1 && bus.ID_rs1 == bus.EX_rd) || (bus.ID_use_rs2 && bus.ID_rs2 == bus.EX_rd));
    branch = state == RUN && bus.EX_branch_taken;
    mdu_go = state == RUN && !branch && bus.EX_mdu_start && !bus.mdu_done;
    lu = state == RUN && !branch && !bus.EX_mdu_start && load_use;
    wd = state == MDU_WAIT && !bus.mdu_done && wait_cnt == WW'(MDU_TIMEOUT - 1);
    hold = mdu_go || (state == MDU_WAIT && !bus.mdu_done && !wd);
    pc_wr = !rst && !hold && !lu;
  end
  assign bus.PC_write = pc_wr;
  assign bus.IFID_write = pc_wr;
  assign bus.IDEX_write = !rst && !hold;
  assign bus.IFID_flush = rst || branch;
  assign bus.IDEX_flush = rst || branch || lu;
  assign bus.EXMEM_flush = rst || hold;
  assign bus.mdu_timeout = timeout_q;
  assign bus.stall_cycles = stall_q;
  assign bus.flush_count = flush_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      wait_cnt <= '0;
      timeout_q <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (mdu_go) begin
        state <= MDU_WAIT;
        wait_cnt <= '0;
      end else if (state == MDU_WAIT) begin
        state <= (bus.mdu_done || wd) ? RUN : MDU_WAIT;
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (wd) timeout_q <= 1'b1;
      if (!pc_wr && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (branch && flush_q != '1) flush_q <= flush_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed-vector bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  hazard_stall_ctrl_if #(.CNT_W(32)) bus ();
  hazard_stall_ctrl #(.MDU_TIMEOUT(8), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic idle();
    bus.ID_rs1 = 5'd0; bus.ID_rs2 = 5'd0; bus.EX_rd = 5'd0;
    bus.ID_use_rs1 = 1'b0; bus.ID_use_rs2 = 1'b0; bus.EX_MemRead = 1'b0;
    bus.EX_branch_taken = 1'b0; bus.EX_mdu_start = 1'b0; bus.mdu_done = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #1;
    checks++; if ({bus.PC_write, bus.IFID_write, bus.IDEX_write} !== 3'b000) begin errors++; $display("FAIL reset_writes got=%b exp=000", {bus.PC_write, bus.IFID_write, bus.IDEX_write}); end
    checks++; if ({bus.IFID_flush, bus.IDEX_flush, bus.EXMEM_flush} !== 3'b111) begin errors++; $display("FAIL reset_flushes got=%b exp=111", {bus.IFID_flush, bus.IDEX_flush, bus.EXMEM_flush}); end
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.stall_cycles !== 32'd0 || bus.flush_count !== 32'd0 || bus.mdu_timeout !== 1'b0) begin errors++; $display("FAIL reset_state got=%0d/%0d/%b exp=0/0/0", bus.stall_cycles, bus.flush_count, bus.mdu_timeout); end
    checks++; if ({bus.PC_write, bus.IFID_write, bus.IDEX_write, bus.IFID_flush, bus.IDEX_flush, bus.EXMEM_flush} !== 6'b111000) begin errors++; $display("FAIL run_defaults got=%b exp=111000", {bus.PC_write, bus.IFID_write, bus.IDEX_write, bus.IFID_flush, bus.IDEX_flush, bus.EXMEM_flush}); end
    tick();
  endtask

  task automatic test_load_use();
    bus.EX_MemRead = 1'b1; bus.EX_rd = 5'd5; bus.ID_rs2 = 5'd5; bus.ID_use_rs2 = 1'b1;
    #1;
    checks++; if ({bus.PC_write, bus.IFID_write, bus.IDEX_write, bus.IDEX_flush, bus.EXMEM_flush} !== 5'b00110) begin errors++; $display("FAIL load_use_rs2 got=%b exp=00110", {bus.PC_write, bus.IFID_write, bus.IDEX_write, bus.IDEX_flush, bus.EXMEM_flush}); end
    tick();
    idle();
    #1;
    checks++; if (bus.stall_cycles !== 32'd1) begin errors++; $display("FAIL load_use_count got=%0d exp=1", bus.stall_cycles); end
    checks++; if (bus.PC_write !== 1'b1) begin errors++; $display("FAIL load_use_one_cycle got=%b exp=1", bus.PC_write); end
    bus.EX_MemRead = 1'b1; bus.EX_rd = 5'd0; bus.ID_rs2 = 5'd0; bus.ID_use_rs2 = 1'b1;
    #1;
    checks++; if (bus.PC_write !== 1'b1 || bus.IDEX_flush !== 1'b0) begin errors++; $display("FAIL load_use_x0 got=%b%b exp=10", bus.PC_write, bus.IDEX_flush); end
    bus.EX_rd = 5'd9; bus.ID_rs1 = 5'd9; bus.ID_use_rs1 = 1'b0; bus.ID_use_rs2 = 1'b0;
    #1;
    checks++; if (bus.PC_write !== 1'b1) begin errors++; $display("FAIL load_use_unused_rs1 got=%b exp=1", bus.PC_write); end
    bus.ID_use_rs1 = 1'b1;
    #1;
    checks++; if (bus.PC_write !== 1'b0 || bus.IDEX_flush !== 1'b1) begin errors++; $display("FAIL load_use_rs1 got=%b%b exp=01", bus.PC_write, bus.IDEX_flush); end
    tick();
    idle();
    #1;
    checks++; if (bus.stall_cycles !== 32'd2) begin errors++; $display("FAIL load_use_count2 got=%0d exp=2", bus.stall_cycles); end
  endtask

  task automatic test_branch();
    bus.EX_MemRead = 1'b1; bus.EX_rd = 5'd5; bus.ID_rs2 = 5'd5; bus.ID_use_rs2 = 1'b1; bus.EX_branch_taken = 1'b1;
    #1;
    checks++; if ({bus.IFID_flush, bus.IDEX_flush, bus.PC_write, bus.IFID_write, bus.EXMEM_flush} !== 5'b11110) begin errors++; $display("FAIL branch_vs_load_use got=%b exp=11110", {bus.IFID_flush, bus.IDEX_flush, bus.PC_write, bus.IFID_write, bus.EXMEM_flush}); end
    tick();
    idle();
    #1;
    checks++; if (bus.flush_count !== 32'd1 || bus.stall_cycles !== 32'd2) begin errors++; $display("FAIL branch_counts got=%0d/%0d exp=1/2", bus.flush_count, bus.stall_cycles); end
  endtask

  task automatic test_mdu_wait();
    bus.EX_mdu_start = 1'b1;
    #1;
    checks++; if ({bus.PC_write, bus.IFID_write, bus.IDEX_write, bus.EXMEM_flush} !== 4'b0001) begin errors++; $display("FAIL mdu_start got=%b exp=0001", {bus.PC_write, bus.IFID_write, bus.IDEX_write, bus.EXMEM_flush}); end
    tick();
    bus.EX_mdu_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.EX_branch_taken = (i == 1);
      #1;
      checks++; if ({bus.PC_write, bus.EXMEM_flush, bus.IFID_flush} !== 3'b010) begin errors++; $display("FAIL mdu_wait_%0d got=%b exp=010", i, {bus.PC_write, bus.EXMEM_flush, bus.IFID_flush}); end
      tick();
    end
    bus.EX_branch_taken = 1'b0;
    bus.mdu_done = 1'b1;
    #1;
    checks++; if ({bus.PC_write, bus.IDEX_write, bus.EXMEM_flush} !== 3'b110) begin errors++; $display("FAIL mdu_release got=%b exp=110", {bus.PC_write, bus.IDEX_write, bus.EXMEM_flush}); end
    tick();
    idle();
    #1;
    checks++; if (bus.stall_cycles !== 32'd6 || bus.flush_count !== 32'd1) begin errors++; $display("FAIL mdu_counts got=%0d/%0d exp=6/1", bus.stall_cycles, bus.flush_count); end
    bus.EX_branch_taken = 1'b1;
    #1;
    checks++; if (bus.IFID_flush !== 1'b1 || bus.PC_write !== 1'b1) begin errors++; $display("FAIL mdu_back_to_run got=%b%b exp=11", bus.IFID_flush, bus.PC_write); end
    tick();
    idle();
  endtask

  task automatic test_mdu_same_cycle();
    bus.EX_mdu_start = 1'b1; bus.mdu_done = 1'b1;
    #1;
    checks++; if ({bus.PC_write, bus.EXMEM_flush} !== 2'b10) begin errors++; $display("FAIL mdu_instant got=%b exp=10", {bus.PC_write, bus.EXMEM_flush}); end
    tick();
    idle();
    bus.EX_branch_taken = 1'b1;
    #1;
    checks++; if (bus.IFID_flush !== 1'b1 || bus.stall_cycles !== 32'd6) begin errors++; $display("FAIL mdu_instant_run got=%b/%0d exp=1/6", bus.IFID_flush, bus.stall_cycles); end
    tick();
    idle();
    #1;
    checks++; if (bus.flush_count !== 32'd3) begin errors++; $display("FAIL flush_count got=%0d exp=3", bus.flush_count); end
  endtask

  task automatic test_watchdog();
    int n = 0;
    bool_loop: begin
      bus.EX_mdu_start = 1'b1;
      for (int i = 0; i < 20; i++) begin
        #1;
        if (bus.PC_write !== 1'b0) disable bool_loop;
        n++;
        tick();
        bus.EX_mdu_start = 1'b0;
      end
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL watchdog_stalls got=%0d exp=8", n); end
    checks++; if (bus.mdu_timeout !== 1'b0) begin errors++; $display("FAIL watchdog_early got=%b exp=0", bus.mdu_timeout); end
    tick();
    idle();
    #1;
    checks++; if (bus.mdu_timeout !== 1'b1 || bus.stall_cycles !== 32'd14) begin errors++; $display("FAIL watchdog_flag got=%b/%0d exp=1/14", bus.mdu_timeout, bus.stall_cycles); end
    bus.EX_branch_taken = 1'b1;
    #1;
    checks++; if (bus.IFID_flush !== 1'b1) begin errors++; $display("FAIL watchdog_run got=%b exp=1", bus.IFID_flush); end
    tick();
    idle();
    tick(); tick();
    checks++; if (bus.mdu_timeout !== 1'b1) begin errors++; $display("FAIL watchdog_sticky got=%b exp=1", bus.mdu_timeout); end
  endtask

  task automatic test_reset_mid_wait();
    bus.EX_mdu_start = 1'b1;
    tick();
    idle();
    tick();
    rst = 1'b1;
    #1;
    checks++; if ({bus.IFID_flush, bus.IDEX_flush, bus.EXMEM_flush, bus.PC_write} !== 4'b1110) begin errors++; $display("FAIL rst_mid_wait_out got=%b exp=1110", {bus.IFID_flush, bus.IDEX_flush, bus.EXMEM_flush, bus.PC_write}); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.stall_cycles !== 32'd0 || bus.flush_count !== 32'd0 || bus.mdu_timeout !== 1'b0) begin errors++; $display("FAIL rst_mid_wait_state got=%0d/%0d/%b exp=0/0/0", bus.stall_cycles, bus.flush_count, bus.mdu_timeout); end
    checks++; if (bus.PC_write !== 1'b1 || bus.EXMEM_flush !== 1'b0) begin errors++; $display("FAIL rst_mid_wait_run got=%b%b exp=10", bus.PC_write, bus.EXMEM_flush); end
    bus.EX_branch_taken = 1'b1;
    #1;
    checks++; if (bus.IFID_flush !== 1'b1) begin errors++; $display("FAIL rst_mid_wait_branch got=%b exp=1", bus.IFID_flush); end
    tick();
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mdu_wait();
    test_mdu_same_cycle();
    test_watchdog();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
